// File: rtl/pwm_dac_mc.sv
// Multi-channel 1-bit DAC with double-buffered duties and frame-aligned switching
// between PWM and first-order sigma-delta modulation.
module pwm_dac_mc #(
    parameter int N  = 8,
    parameter int CH = 4,
    parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          mode,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [N-1:0]  wr_data,
    output logic          wr_ready,
    output logic [CH-1:0] dac_out,
    output logic          frame_start
);

    localparam logic [N-1:0] CTR_MAX = '1;

    logic [N-1:0] ctr;
    logic [N-1:0] shadow      [CH];
    logic [N-1:0] shadow_next [CH];
    logic [N-1:0] active      [CH];
    logic [N-1:0] acc         [CH];
    logic [N:0]   sd_sum      [CH];
    logic         active_mode;
    logic         run;
    logic         commit;
    logic         wr_accept;

    assign commit    = enable && (ctr == CTR_MAX);
    assign wr_ready  = !commit;
    assign wr_accept = wr_en && wr_ready;

    // Shadow contents including this cycle's write; channels >= CH never match.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            shadow_next[i] = (wr_accept && (wr_ch == CW'(i))) ? wr_data : shadow[i];
            sd_sum[i]      = {1'b0, acc[i]} + {1'b0, active[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr         <= '0;
            run         <= 1'b0;
            frame_start <= 1'b0;
            dac_out     <= '0;
            active_mode <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
                acc[i]    <= '0;
            end
        end else begin
            run <= enable;
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= shadow_next[i];
            end
            if (!enable) begin
                // Idle tracks the shadow (including a same-cycle write) so the
                // first frame after enable already uses the latest values.
                ctr         <= '0;
                frame_start <= 1'b0;
                dac_out     <= '0;
                active_mode <= mode;
                for (int i = 0; i < CH; i++) begin
                    active[i] <= shadow_next[i];
                    acc[i]    <= '0;
                end
            end else begin
                ctr         <= ctr + 1'b1;
                frame_start <= commit || !run;
                for (int i = 0; i < CH; i++) begin
                    if (active_mode) begin
                        dac_out[i] <= sd_sum[i][N];
                        acc[i]     <= sd_sum[i][N-1:0];
                    end else begin
                        dac_out[i] <= (active[i] > ctr);
                    end
                end
                if (commit) begin
                    active_mode <= mode;
                    for (int i = 0; i < CH; i++) begin
                        active[i] <= shadow[i];
                        if (mode != active_mode) begin
                            acc[i] <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_dac_mc.sv
// Self-checking bench for pwm_dac_mc: frame-level behavioural model checked every
// cycle, plus hand-computed per-frame ones counts and bit patterns.
module tb_pwm_dac_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       mode;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [3:0] dac_out;
    logic       frame_start;

    pwm_dac_mc #(.N(8), .CH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .dac_out     (dac_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt [4];
    logic [3:0] fs_dac;
    bit fs_found;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    endtask

    // Model: frame position, shadow/active duties and a running accumulator sum.
    int m_shadow [4];
    int m_act    [4];
    int m_acc    [4];
    int m_mode;
    int m_pos;
    bit m_prev_en;
    bit m_commit;
    bit model_valid = 1'b0;
    logic [3:0] exp_dac;
    logic exp_fs;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = 0;
                m_act[i]    = 0;
                m_acc[i]    = 0;
            end
            m_mode = 0; m_pos = 0; m_prev_en = 1'b0;
            exp_dac = 4'b0; exp_fs = 1'b0;
        end else begin
            m_commit = enable && (m_pos == 255);
            if (wr_en && !m_commit) m_shadow[wr_ch] = int'(wr_data);
            if (enable) begin
                exp_fs = m_commit || !m_prev_en;
                for (int i = 0; i < 4; i++) begin
                    if (m_mode == 0) begin
                        exp_dac[i] = (m_act[i] > m_pos);
                    end else begin
                        exp_dac[i] = ((m_acc[i] + m_act[i]) >= 256);
                        m_acc[i]   = (m_acc[i] + m_act[i]) % 256;
                    end
                end
                if (m_commit) begin
                    if (int'(mode) != m_mode) begin
                        for (int i = 0; i < 4; i++) m_acc[i] = 0;
                    end
                    m_act  = m_shadow;
                    m_mode = int'(mode);
                end
                m_pos = (m_pos + 1) % 256;
            end else begin
                exp_fs = 1'b0;
                exp_dac = 4'b0;
                m_pos = 0;
                for (int i = 0; i < 4; i++) m_acc[i] = 0;
                m_act  = m_shadow;
                m_mode = int'(mode);
            end
            m_prev_en = enable;
        end
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check_output("model_dac_out", int'(dac_out), int'(exp_dac));
            check_output("model_frame_start", int'(frame_start), int'(exp_fs));
            check_output("model_wr_ready", int'(wr_ready), int'(!(enable && m_pos == 255)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic en, input logic md, input logic we,
                                  input logic [1:0] ch, input logic [7:0] data);
        enable  = en;
        mode    = md;
        wr_en   = we;
        wr_ch   = ch;
        wr_data = data;
    endtask

    task automatic wait_frame();
        fs_found = 1'b0;
        for (int k = 0; k < 600 && !fs_found; k++) begin
            @(negedge clk);
            if (frame_start) begin
                fs_found = 1'b1;
                fs_dac   = dac_out;
            end
        end
        check_output("frame_seen", int'(fs_found), 1);
    endtask

    task automatic count_frame();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        repeat (256) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) cnt[i] += int'(dac_out[i]);
        end
    endtask

    initial begin
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        repeat (3) tick();
        @(negedge clk);
        check_output("reset_dac_out", int'(dac_out), 0);
        check_output("reset_frame_start", int'(frame_start), 0);
        check_output("reset_wr_ready", int'(wr_ready), 1);
        reset = 1'b0;

        // PWM, ch2 = 64 written while running
        apply_stimulus(1'b1, 1'b0, 1'b1, 2'd2, 8'd64);
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        repeat (3) tick();
        wait_frame();
        count_frame();
        check_output("pwm64_ch2", cnt[2], 64);
        check_output("pwm64_ch0", cnt[0], 0);
        check_output("pwm64_ch1", cnt[1], 0);
        check_output("pwm64_ch3", cnt[3], 0);

        // Full-scale and small duties
        apply_stimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'd255);
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'd10);
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        wait_frame();
        count_frame();
        check_output("pwm255_ch3", cnt[3], 255);
        check_output("pwm10_ch0", cnt[0], 10);
        check_output("pwm_ch2_kept", cnt[2], 64);
        check_output("pwm0_ch1", cnt[1], 0);

        // Write in the commit cycle is refused, retry one cycle later lands
        repeat (255) tick();
        apply_stimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'd200);
        @(negedge clk);
        check_output("commit_wr_ready", int'(wr_ready), 0);
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'd200);
        @(negedge clk);
        check_output("retry_wr_ready", int'(wr_ready), 1);
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
        count_frame();
        check_output("dropped_write_ch0", cnt[0], 10);
        count_frame();
        check_output("retried_write_ch0", cnt[0], 200);

        // Switch to sigma-delta mid-frame
        tick();
        apply_stimulus(1'b1, 1'b1, 1'b1, 2'd1, 8'd1);
        tick();
        apply_stimulus(1'b1, 1'b1, 1'b1, 2'd3, 8'd0);
        tick();
        apply_stimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        wait_frame();
        count_frame();
        check_output("sd1_ch1", cnt[1], 1);
        check_output("sd200_ch0", cnt[0], 200);
        check_output("sd64_ch2", cnt[2], 64);
        check_output("sd0_ch3", cnt[3], 0);

        // Enable drop mid-frame, then restart with ch1 = 128
        apply_stimulus(1'b1, 1'b1, 1'b1, 2'd1, 8'd128);
        tick();
        apply_stimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        repeat (9) tick();
        apply_stimulus(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
        tick();
        @(negedge clk);
        check_output("disable_dac_out", int'(dac_out), 0);
        check_output("disable_frame_start", int'(frame_start), 0);
        repeat (4) tick();
        apply_stimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        tick();
        wait_frame();
        check_output("restart_fs_dac", int'(fs_dac), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_output("sd128_pattern", int'(dac_out[1]), (k % 2 == 0) ? 1 : 0);
        end

        // Reset mid-frame while enabled
        repeat (20) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        check_output("midreset_dac_out", int'(dac_out), 0);
        check_output("midreset_frame_start", int'(frame_start), 0);
        check_output("midreset_wr_ready", int'(wr_ready), 1);
        reset = 1'b0;
        tick();
        wait_frame();
        count_frame();
        for (int i = 0; i < 4; i++) check_output("after_reset_zero", cnt[i], 0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_dac_mc.md
PWM_DAC_MC -- requirements
Module: pwm_dac_mc

Interface
REQ-001 Parameter N, default 8, duty/counter width in bits (N >= 2).
REQ-002 Parameter CH, default 4, number of independent output channels (CH >= 1).
REQ-003 Parameter CW, default max(1,$clog2(CH)), channel-select width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  1 = run, 0 = idle (outputs low, counter held).
REQ-007 mode  input  1  requested mode: 0 = PWM, 1 = first-order sigma-delta.
REQ-008 wr_en  input  1  duty write request.
REQ-009 wr_ch  input  CW  target channel of write.
REQ-010 wr_data  input  N  duty value for target channel.
REQ-011 wr_ready  output  1  write accepted when wr_en && wr_ready at clock edge.
REQ-012 dac_out  output  CH  per-channel 1-bit DAC output, registered.
REQ-013 frame_start  output  1  one-cycle pulse marking first cycle of each frame.

Function
REQ-014 Block SHALL keep per-channel shadow duty registers (N bits) and active duty registers (N bits); only active values drive outputs.
REQ-015 Accepted write SHALL store wr_data into shadow[wr_ch] at that edge; wr_ch >= CH SHALL be accepted and discarded.
REQ-016 wr_ready SHALL be 1 except in the commit cycle (enable=1 and ctr == 2^N-1), where it SHALL be 0 and wr_en SHALL have no effect.
REQ-017 Frame counter ctr (N bits) SHALL increment by 1 per cycle while enable=1, wrapping 2^N-1 -> 0.
REQ-018 Commit: on the edge where ctr == 2^N-1 and enable=1, all active duties SHALL load from shadow and active mode SHALL load from mode input, atomically for all channels.
REQ-019 Mode and duty changes SHALL never take effect mid-frame while enable=1.
REQ-020 frame_start SHALL be 1 in the cycle after each commit edge and in the first cycle after enable rises; otherwise 0.
REQ-021 PWM mode: dac_out[i] SHALL be registered (active[i] > ctr), one cycle latency from ctr value.
REQ-022 PWM boundaries: duty 0 -> output constantly 0; duty 2^N-1 -> high 2^N-1 of every 2^N cycles.
REQ-023 Sigma-delta mode: per-channel accumulator acc[i] (N bits) SHALL update acc[i] <= acc[i] + active[i] modulo 2^N each cycle; dac_out[i] SHALL register the carry-out of that addition.
REQ-024 Sigma-delta: ones density per 2^N-cycle window SHALL equal active[i] exactly; duty 0 -> constant 0.
REQ-025 Accumulators SHALL clear to 0 on every commit at which active mode changes.
REQ-026 enable=0: ctr held at 0, accumulators cleared, dac_out = 0 (registered), active duties and active mode loaded from shadow/mode every cycle; shadow writes still accepted (wr_ready=1).
REQ-027 Write and commit to same channel in same cycle cannot occur (REQ-016); write during enable=0 SHALL be visible on the first frame after enable rises.
REQ-028 All arithmetic SHALL be unsigned, N-bit, modular; no saturation.

Reset
REQ-029 Reset SHALL clear ctr, all shadow and active duties, all accumulators, active mode (PWM), dac_out, frame_start to 0; wr_ready SHALL be 1 after reset.
REQ-030 Reset SHALL take priority over enable, wr_en and commit in the same cycle; reset mid-frame SHALL abort the frame with no commit.

Verification
REQ-031 N=8, CH=4, PWM: write ch2=64 while enabled -> after next commit, dac_out[2] high exactly 64 of each 256 cycles, other channels 0.
REQ-032 Write ch0=200 asserted in commit cycle -> wr_ready=0, write dropped, shadow[0] unchanged; retry next cycle accepted.
REQ-033 Sigma-delta, ch1=1 -> exactly one high cycle per 256; ch1=128 -> alternating 0/1 pattern after accumulator clear.
REQ-034 Change mode 0->1 mid-frame -> PWM pattern continues until commit, frame_start pulses, then sigma-delta starts with acc=0.
REQ-035 Duty 255 PWM -> 255 high, 1 low per frame; duty 0 -> never high in either mode.
REQ-036 enable dropped mid-frame then reasserted, and reset mid-frame -> dac_out=0 next cycle, ctr=0, frame_start pulse on restart, no stale commit.
